// File: rtl/proc_control_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM: opcodes, step states
// and instruction-register field positions.
package proc_control_pkg;

  localparam int NREG = 8;
  localparam int IR_W = 9;

  localparam int OP_LSB = 6;
  localparam int RX_LSB = 3;
  localparam int RY_LSB = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  function automatic logic isArith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-bit register index to 8-bit one-hot strobe, forced to zero when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] idx_i,
  output logic [7:0] onehot_o
);

  assign onehot_o = en_i ? (8'b0000_0001 << idx_i) : 8'b0000_0000;

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control FSM for the simple CPU datapath: decodes the external IR
// and drives register, ALU and bus-select strobes for each step T0..T3.
module proc_control
  import proc_control_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
  output logic            irin,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            gout,
  output logic            dinout,
  output logic            ain,
  output logic            gin,
  output logic            sub,
  output logic            done,
  output logic            busy
);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       rinEn;
  logic       routEn;
  logic [2:0] routIdx;

  assign opcode = ir[OP_LSB +: 3];
  assign rx     = ir[RX_LSB +: 3];
  assign ry     = ir[RY_LSB +: 3];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Non-arithmetic opcodes seen in T2/T3 only arise from an ir change mid-instruction; bail to T0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      T0: state_d = run ? T1 : T0;
      T1: state_d = isArith(opcode) ? T2 : T0;
      T2: state_d = isArith(opcode) ? T3 : T0;
      T3: state_d = T0;
      default: state_d = T0;
    endcase
  end

  always_comb begin
    irin    = 1'b0;
    gout    = 1'b0;
    dinout  = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    sub     = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    rinEn   = 1'b0;
    routEn  = 1'b0;
    routIdx = ry;
    if (!reset) begin
      busy = (state_q != T0);
      unique case (state_q)
        T0: irin = run;
        T1: begin
          if (opcode == OP_MV) begin
            routEn = 1'b1;
            rinEn  = 1'b1;
            done   = 1'b1;
          end else if (opcode == OP_MVI) begin
            dinout = 1'b1;
            rinEn  = 1'b1;
            done   = 1'b1;
          end else if (isArith(opcode)) begin
            routEn  = 1'b1;
            routIdx = rx;
            ain     = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        T2: begin
          if (isArith(opcode)) begin
            routEn = 1'b1;
            gin    = 1'b1;
            sub    = (opcode == OP_SUB);
          end
        end
        T3: begin
          if (isArith(opcode)) begin
            gout  = 1'b1;
            rinEn = 1'b1;
            done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dec3to8 rin_sel (
    .en_i     (rinEn),
    .idx_i    (rx),
    .onehot_o (rin)
  );

  dec3to8 rout_sel (
    .en_i     (routEn),
    .idx_i    (routIdx),
    .onehot_o (rout)
  );

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control wired to a behavioural datapath (IR, 8x16 regfile,
// bus mux, A/G ALU); register writes are predicted into a scoreboard and retired on done.
module tb_proc_control;

  logic        clock;
  logic        reset;
  logic        run;
  logic [8:0]  ir;
  logic        irin;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        gout;
  logic        dinout;
  logic        ain;
  logic        gin;
  logic        sub;
  logic        done;
  logic        busy;

  logic [15:0] din;
  logic [15:0] bus;
  logic [15:0] regs [8];
  logic [15:0] aReg;
  logic [15:0] gReg;
  logic [23:0] obsVec;

  logic [7:0]  expRinQ [$];
  logic [15:0] expValQ [$];

  int checks;
  int failures;

  proc_control dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .ir     (ir),
    .irin   (irin),
    .rin    (rin),
    .rout   (rout),
    .gout   (gout),
    .dinout (dinout),
    .ain    (ain),
    .gin    (gin),
    .sub    (sub),
    .done   (done),
    .busy   (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign obsVec = {irin, rin, rout, gout, dinout, ain, gin, sub, done, busy};

  // Bus mux driven by the DUT's select strobes.
  always_comb begin
    bus = 16'h0000;
    if (dinout) bus = din;
    else if (gout) bus = gReg;
    else begin
      for (int n = 0; n < 8; n++) if (rout[n]) bus = regs[n];
    end
  end

  // Datapath registers loaded by the DUT's write strobes.
  always @(posedge clock) begin
    if (irin) ir <= din[8:0];
    for (int n = 0; n < 8; n++) if (rin[n]) regs[n] <= bus;
    if (ain) aReg <= bus;
    if (gin) gReg <= sub ? (aReg - bus) : (aReg + bus);
  end

  // Retire scoreboard entries on done and check the bus/write invariants every cycle.
  always @(negedge clock) begin
    checks++;
    assert ($onehot0({rout, gout, dinout})) else begin
      failures++;
      $error("FAIL busOneHot observed=%h expected=onehot0", {rout, gout, dinout});
    end
    checks++;
    assert ($onehot0(rin)) else begin
      failures++;
      $error("FAIL rinOneHot observed=%h expected=onehot0", rin);
    end
    if (done) begin
      checks++;
      assert (expRinQ.size() != 0) else begin
        failures++;
        $error("FAIL sbUnexpectedDone observed=%0d expected=1", expRinQ.size());
      end
      if (expRinQ.size() != 0) begin
        logic [7:0]  eRin;
        logic [15:0] eVal;
        eRin = expRinQ.pop_front();
        eVal = expValQ.pop_front();
        checks++;
        assert (rin === eRin) else begin
          failures++;
          $error("FAIL sbRin observed=%h expected=%h", rin, eRin);
        end
        if (eRin != 8'h00) begin
          checks++;
          assert (bus === eVal) else begin
            failures++;
            $error("FAIL sbBus observed=%h expected=%h", bus, eVal);
          end
        end
      end
    end
  end

  function automatic logic [23:0] ov(input logic irin_, input logic [7:0] rin_,
                                     input logic [7:0] rout_, input logic gout_,
                                     input logic dinout_, input logic ain_, input logic gin_,
                                     input logic sub_, input logic done_, input logic busy_);
    return {irin_, rin_, rout_, gout_, dinout_, ain_, gin_, sub_, done_, busy_};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] expVec);
    #1;
    checks++;
    assert (obsVec === expVec) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obsVec, expVec);
    end
  endtask

  task automatic checkReg(input string tag, input int idx, input logic [15:0] expVal);
    checks++;
    assert (regs[idx] === expVal) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, regs[idx], expVal);
    end
  endtask

  // Called in T0: fetch instr with a run pulse, optionally predicting its write, land in T1.
  task automatic applyStimulus(input logic [8:0] instr, input logic predict,
                               input logic [7:0] eRin, input logic [15:0] eVal);
    run = 1'b1;
    din = {7'b0, instr};
    if (predict) begin
      expRinQ.push_back(eRin);
      expValQ.push_back(eVal);
    end
    checkOutput("fetchT0", ov(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    run = 1'b0;
  endtask

  task automatic loadImm(input logic [8:0] instr, input int idx, input logic [15:0] val);
    applyStimulus(instr, 1'b1, 8'h01 << idx, val);
    din = val;
    checkOutput("mviT1", ov(0, 8'h01 << idx, 8'h00, 0, 1, 0, 0, 0, 1, 1));
    tick();
    checkReg("mviReg", idx, val);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    run      = 1'b1;
    din      = 16'h0000;

    // Reset held two cycles with run high
    tick();
    checkOutput("reset1", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("reset2", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    run   = 1'b0;
    checkOutput("idleT0", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

    // mvi R5,0x42 then mv R2,R5
    loadImm(9'b001_101_000, 5, 16'h0042);
    applyStimulus(9'b000_010_101, 1'b1, 8'h04, 16'h0042);
    checkOutput("mvT1", ov(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1, 1));
    tick();
    checkOutput("mvBackT0", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    checkReg("mvR2", 2, 16'h0042);

    // mvi R7,0xAA
    loadImm(9'b001_111_000, 7, 16'h00AA);

    // add R0,R1 : 100 + 50
    loadImm(9'b001_000_000, 0, 16'd100);
    loadImm(9'b001_001_000, 1, 16'd50);
    applyStimulus(9'b010_000_001, 1'b1, 8'h01, 16'd150);
    checkOutput("addT1", ov(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 1));
    tick();
    checkOutput("addT2", ov(0, 8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 1));
    tick();
    checkOutput("addT3", ov(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    tick();
    checkReg("addR0", 0, 16'd150);

    // sub R0,R1 : 200 - 25
    loadImm(9'b001_000_000, 0, 16'd200);
    loadImm(9'b001_001_000, 1, 16'd25);
    applyStimulus(9'b011_000_001, 1'b1, 8'h01, 16'd175);
    checkOutput("subT1", ov(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 1));
    tick();
    checkOutput("subT2", ov(0, 8'h00, 8'h02, 0, 0, 0, 1, 1, 0, 1));
    tick();
    checkOutput("subT3", ov(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    tick();
    checkReg("subR0", 0, 16'd175);

    // Reset during T2 of add R0,R1: no done, no write
    applyStimulus(9'b010_000_001, 1'b0, 8'h00, 16'h0000);
    checkOutput("abortT1", ov(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 1));
    tick();
    reset = 1'b1;
    checkOutput("abortRst", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    checkOutput("abortT0", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkReg("abortR0", 0, 16'd175);

    // Reserved opcode completes as a NOP
    applyStimulus(9'b111_000_000, 1'b1, 8'h00, 16'h0000);
    checkOutput("nopT1", ov(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tick();

    // Back-to-back: mv R3,R0 then add R3,R3 with run held high
    applyStimulus(9'b000_011_000, 1'b1, 8'h08, 16'd175);
    run = 1'b1;
    din = {7'b0, 9'b010_011_011};
    expRinQ.push_back(8'h08);
    expValQ.push_back(16'd350);
    checkOutput("b2bMvT1", ov(0, 8'h08, 8'h01, 0, 0, 0, 0, 0, 1, 1));
    tick();
    checkOutput("b2bFetch", ov(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tick();
    run = 1'b0;
    checkOutput("b2bAddT1", ov(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 1));
    tick();
    checkOutput("b2bAddT2", ov(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0, 1));
    tick();
    checkOutput("b2bAddT3", ov(0, 8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 1));
    tick();
    checkReg("b2bR3", 3, 16'd350);

    tick();
    checks++;
    assert (expRinQ.size() == 0) else begin
      failures++;
      $error("FAIL sbDrain observed=%0d expected=0", expRinQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
